w_buffer_loader: RTL and testbench

W_BUFFER_LOADER -- requirements
Module: w_buffer_loader

---
 rtl/w_buf_pkg.sv | 14 +
 rtl/w_buffer_loader.sv | 137 +++++++++++++
 tb/tb_w_buffer_loader.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/w_buf_pkg.sv
// Shared weight-buffer definitions: default geometry and the loader/reader FSM state encoding.
package w_buf_pkg;

    localparam int unsigned DEF_RAM_SIZE  = 256;
    localparam int unsigned DEF_ARRAY_M   = 8;
    localparam int unsigned DEF_WGT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/w_buffer_loader.sv
// Streams weight beats into ARRAY_M per-column banks at consecutive (wrapping) addresses.
// Optional WLOAD_LAST_CHECK_EN adds s_last framing checks with a sticky err flag.
module w_buffer_loader
    import w_buf_pkg::*;
#(
    parameter int unsigned RAM_SIZE        = DEF_RAM_SIZE,
    parameter int unsigned ADDR_WIDTH      = $clog2(RAM_SIZE),
    parameter int unsigned ARRAY_M         = DEF_ARRAY_M,
    parameter int unsigned WGT_WIDTH       = DEF_WGT_WIDTH,
    parameter int unsigned WBUF_DATA_WIDTH = ARRAY_M * WGT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [ADDR_WIDTH:0]        num_words,
    input  logic [$clog2(ARRAY_M):0]   num_cols,
    input  logic [WBUF_DATA_WIDTH-1:0] s_data,
    input  logic                       s_valid,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic [ARRAY_M-1:0]         wr_en,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic [WBUF_DATA_WIDTH-1:0] wr_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned COL_W = $clog2(ARRAY_M) + 1;

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_WIDTH-1:0]  ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       words_q;
    logic [ARRAY_M-1:0]     mask_q;
    logic [ARRAY_M-1:0]     mask_c;
    logic                   hs_c;
    logic                   final_c;
    logic                   abort_c;

    assign hs_c    = s_valid && s_ready;
    assign final_c = (count_q == (words_q - CNT_W'(1)));

    // Columns at or above num_cols stay unwritten; oversize num_cols saturates to all columns.
    always_comb begin
        mask_c = '0;
        for (int j = 0; j < ARRAY_M; j++) begin
            mask_c[j] = (num_cols > COL_W'(j));
        end
    end

`ifdef WLOAD_LAST_CHECK_EN
    logic err_set_c;

    assign abort_c   = hs_c && s_last && !final_c;
    assign err_set_c = abort_c || (hs_c && final_c && !s_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (state == IDLE && start) begin
            err <= 1'b0;
        end else if (err_set_c) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_s_last;

    assign unused_s_last = s_last;
    assign abort_c       = 1'b0;
    assign err           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_words == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (hs_c && (final_c || abort_c)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status flags are registered copies of the next state so they track the FSM cycle-exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            words_q <= '0;
            mask_q  <= '0;
        end else begin
            s_ready <= (state_next == LOAD);
            busy    <= (state_next != IDLE);
            done    <= (state_next == DONE);
            wr_en   <= '0;
            if (state == IDLE && start) begin
                ptr_q   <= base_addr;
                words_q <= num_words;
                mask_q  <= mask_c;
                count_q <= '0;
            end else if (hs_c) begin
                wr_en   <= mask_q;
                wr_addr <= ptr_q;
                wr_data <= s_data;
                count_q <= count_q + CNT_W'(1);
                ptr_q   <= (ptr_q == ADDR_WIDTH'(RAM_SIZE - 1)) ? '0 : ptr_q + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_w_buffer_loader.sv
// Scoreboard bench for w_buffer_loader: expected bank writes queued at start, popped by a monitor.
module tb_w_buffer_loader;

    localparam int unsigned RAM = 256;
    localparam int unsigned AW  = 8;
    localparam int unsigned M   = 8;
    localparam int unsigned WW  = 8;
    localparam int unsigned DW  = M * WW;
    localparam int unsigned CW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic [CW-1:0] num_cols;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [M-1:0]  wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    w_buffer_loader #(
        .RAM_SIZE(RAM), .ADDR_WIDTH(AW), .ARRAY_M(M), .WGT_WIDTH(WW), .WBUF_DATA_WIDTH(DW)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_words(num_words), .num_cols(num_cols), .s_data(s_data),
        .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [M-1:0]  mask;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] beat_mem [0:RAM-1];
    int            n_checks  = 0;
    int            n_pass    = 0;
    int            done_cnt  = 0;
    int            exp_done  = 0;
    int            last_pos  = 0;
    bit            exp_err   = 1'b0;
    bit            chk_busy  = 1'b0;

    task automatic check(input bit ok, input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic check_idle(input string name);
        check(s_ready == 1'b0, {name, "_s_ready"}, DW'(s_ready), '0);
        check(wr_en == '0,     {name, "_wr_en"},   DW'(wr_en),   '0);
        check(busy == 1'b0,    {name, "_busy"},    DW'(busy),    '0);
        check(done == 1'b0,    {name, "_done"},    DW'(done),    '0);
        check(err == 1'b0,     {name, "_err"},     DW'(err),     '0);
        check(wr_addr == '0,   {name, "_wr_addr"}, DW'(wr_addr), '0);
        check(wr_data == '0,   {name, "_wr_data"}, wr_data,      '0);
    endtask

    // Reference model: the k-th written beat lands at (base+k) mod RAM with the saturated column mask.
    task automatic issue_load(input int base, input int words, input int cols, input int lpos,
                              input bit pattern, output int nb);
        int           c;
        logic [M-1:0] mask;
        exp_t         e;
        for (int k = 0; k < words; k++) begin
            if (pattern) beat_mem[k] = {M{WW'(k + 1)}};
            else         beat_mem[k] = {$urandom, $urandom};
        end
        c       = (cols < int'(M)) ? cols : int'(M);
        mask    = M'((1 << c) - 1);
        nb      = words;
        exp_err = 1'b0;
`ifdef WLOAD_LAST_CHECK_EN
        if (words > 0 && lpos < words - 1) begin
            nb      = lpos + 1;
            exp_err = 1'b1;
        end else if (words > 0 && lpos != words - 1) begin
            exp_err = 1'b1;
        end
`endif
        if (mask != '0) begin
            for (int k = 0; k < nb; k++) begin
                e.addr = AW'((base + k) % int'(RAM));
                e.data = beat_mem[k];
                e.mask = mask;
                sb.push_back(e);
            end
        end
        last_pos = lpos;
        exp_done++;
        @(negedge clk);
        base_addr = AW'(base);
        num_words = (AW + 1)'(words);
        num_cols  = CW'(cols);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = AW'($urandom);
        num_words = (AW + 1)'($urandom);
        num_cols  = CW'($urandom);
    endtask

    // mode 0: back-to-back, 1: valid toggles every cycle, 2: random bubbles
    task automatic drive_beats(input int from, input int to, input int mode);
        int k      = from;
        int budget = 4 * (to - from) + 20;
        bit v;
        while (k < to && budget > 0) begin
            @(negedge clk);
            budget--;
            case (mode)
                0:       v = 1'b1;
                1:       v = ~s_valid;
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            s_valid = v;
            s_data  = beat_mem[k];
            s_last  = (k == last_pos);
            if (v && s_ready) k++;
        end
        check(k == to, "beat_budget", DW'(k), DW'(to));
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt < exp_done && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(done_cnt == exp_done, "done_count", DW'(done_cnt), DW'(exp_done));
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every strobe must match the head of the scoreboard; done must coincide with the last one.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en != '0) begin
                if (sb.size() == 0) begin
                    check(1'b0, "extra_write", DW'(wr_en), '0);
                end else begin
                    mon_e = sb.pop_front();
                    check(wr_en == mon_e.mask,   "wr_en",   DW'(wr_en),   DW'(mon_e.mask));
                    check(wr_addr == mon_e.addr, "wr_addr", DW'(wr_addr), DW'(mon_e.addr));
                    check(wr_data == mon_e.data, "wr_data", wr_data,      mon_e.data);
                end
            end
            if (chk_busy) begin
                chk_busy <= 1'b0;
                check(busy == 1'b0 && done == 1'b0, "idle_after_done", DW'({busy, done}), '0);
            end
            if (done) begin
                done_cnt++;
                chk_busy <= 1'b1;
                check(sb.size() == 0, "writes_pending_at_done", DW'(sb.size()), '0);
                check(err == exp_err, "err_at_done", DW'(err), DW'(exp_err));
                check(busy == 1'b1,   "busy_at_done", DW'(busy), DW'(1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int words;
        int lpos;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        num_cols  = '0;
        s_data    = '0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        issue_load(0, 8, 8, 7, 1'b1, nb);
        drive_beats(0, nb, 0);
        wait_done();

        issue_load(250, 10, 3, 9, 1'b0, nb);
        drive_beats(0, nb, 1);
        wait_done();

        issue_load(5, 0, 8, 0, 1'b0, nb);
        repeat (3) begin
            check(s_ready == 1'b0, "zero_words_s_ready", DW'(s_ready), '0);
            @(negedge clk);
        end
        wait_done();

        // Mid-load restart is ignored; reset then aborts with start and s_valid also high.
        issue_load(40, 8, 8, 7, 1'b0, nb);
        drive_beats(0, 2, 2);
        @(negedge clk);
        start     = 1'b1;
        base_addr = AW'(99);
        num_words = (AW + 1)'(5);
        @(negedge clk);
        start = 1'b0;
        drive_beats(2, 4, 2);
        reset   = 1'b1;
        start   = 1'b1;
        s_valid = 1'b1;
        @(posedge clk);
        sb.delete();
        exp_done--;
        @(negedge clk);
        check_idle("reset_mid_load");
        reset   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        check(busy == 1'b0, "aborted_busy", DW'(busy), '0);

        issue_load(16, 2, 8, 1, 1'b0, nb);
        drive_beats(0, nb, 2);
        wait_done();

        issue_load(60, 4, 8, 1, 1'b0, nb);
        drive_beats(0, nb, 0);
        wait_done();
        repeat (3) begin
            check(err == exp_err, "err_hold", DW'(err), DW'(exp_err));
            @(negedge clk);
        end

        for (int i = 0; i < 8; i++) begin
            words = $urandom_range(0, 20);
            lpos  = (words == 0) ? 0 :
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, words) : words - 1;
            issue_load($urandom_range(0, RAM - 1), words, $urandom_range(0, 10), lpos, 1'b0, nb);
            if (nb > 0) drive_beats(0, nb, 2);
            wait_done();
        end

        issue_load(7, RAM, 8, RAM - 1, 1'b0, nb);
        drive_beats(0, nb, 2);
        wait_done();

        check(sb.size() == 0, "scoreboard_empty", DW'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
